// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter: shares the five PPU memories between buffered host writes
// and PPU read fetches. PPU reads win every cycle; host writes drain from a
// small FIFO into idle slots. Optional starvation guard: define
// PPU_ARB_STARVE_GUARD_EN to force a FIFO pop after STARVE_LIMIT waiting cycles.
module ppu_mem_arbiter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_chipselect,
  input  logic        host_write,
  input  logic [13:0] host_address,
  input  logic [31:0] host_writedata,
  output logic        host_waitrequest,
  input  logic        ppu_req,
  input  logic [2:0]  ppu_sel,
  input  logic [10:0] ppu_addr,
  output logic        ppu_gnt,
  output logic        ppu_rvalid,
  output logic        rw_tile_buffer,
  output logic        rw_tile_graphics,
  output logic        rw_sprite_graphics,
  output logic        rw_color_palettes,
  output logic        rw_OAM,
  output logic [8:0]  addr_tile_buffer,
  output logic [10:0] addr_tile_graphics,
  output logic [10:0] addr_sprite_graphics,
  output logic [2:0]  addr_color_palettes,
  output logic [7:0]  addr_OAM,
  output logic [31:0] write_data_tile_buffer,
  output logic [31:0] write_data_tile_graphics,
  output logic [31:0] write_data_sprite_graphics,
  output logic [23:0] write_data_color_palettes,
  output logic [31:0] write_data_OAM,
  output logic [7:0]  dropped_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } host_wr_t;

  host_wr_t       fifo [FIFO_DEPTH];
  host_wr_t       head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic           full, empty, push, pop;
  logic [2:0]     head_region;
  logic           ppu_mapped, gnt_now, mem_read, force_pop;
  logic [1:0]     vld_pipe;

  // Winning access for this cycle, applied to one memory at the next edge
  logic           acc_valid, acc_wr;
  logic [2:0]     acc_region;
  logic [10:0]    acc_addr;
  logic [31:0]    acc_data;

  assign full             = (count == (PW+1)'(FIFO_DEPTH));
  assign empty            = (count == '0);
  assign host_waitrequest = full;
  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign push             = host_chipselect && host_write && !full;
  assign head             = fifo[rd_ptr];
  assign head_region      = head.addr[13:11];
  assign ppu_mapped       = ppu_req && (ppu_sel <= 3'd4);
  assign pop              = !empty && (!ppu_mapped || force_pop);
  // Unmapped PPU requests touch no memory, so they are granted alongside a pop.
  assign gnt_now          = ppu_req && !(pop && ppu_mapped);
  assign mem_read         = gnt_now && ppu_mapped;
  assign ppu_gnt          = vld_pipe[0];
  assign ppu_rvalid       = vld_pipe[1];

`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] wait_cnt;

  // Count cycles the FIFO head sits unpopped; any pop restarts the count.
  always_ff @(posedge clk) begin
    if (reset || empty || pop)                 wait_cnt <= '0;
    else if (wait_cnt != SW'(STARVE_LIMIT))    wait_cnt <= wait_cnt + 1'b1;
  end

  assign force_pop = !empty && (wait_cnt == SW'(STARVE_LIMIT));
`else
  // Strict PPU priority: the limit only matters when the guard is built in.
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign force_pop = 1'b0;
`endif

  // Select the single memory access (PPU read or host write) for this cycle.
  always_comb begin
    acc_valid  = 1'b0;
    acc_wr     = 1'b0;
    acc_region = ppu_sel;
    acc_addr   = ppu_addr;
    acc_data   = head.data;
    if (mem_read) begin
      acc_valid = 1'b1;
    end else if (pop && (head_region <= 3'd4)) begin
      acc_valid  = 1'b1;
      acc_wr     = 1'b1;
      acc_region = head_region;
      acc_addr   = head.addr[10:0];
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{addr: host_address, data: host_writedata};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Grant -> read-valid pipeline for the 1-cycle RAMs.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[0], gnt_now};
  end

  // Saturating count of writes that targeted an unmapped region.
  always_ff @(posedge clk) begin
    if (reset)
      dropped_count <= '0;
    else if (pop && (head_region > 3'd4) && (dropped_count != 8'hFF))
      dropped_count <= dropped_count + 1'b1;
  end

  // Drive the chosen memory; others read with addr/data held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_tile_buffer             <= 1'b0;
      rw_tile_graphics           <= 1'b0;
      rw_sprite_graphics         <= 1'b0;
      rw_color_palettes          <= 1'b0;
      rw_OAM                     <= 1'b0;
      addr_tile_buffer           <= '0;
      addr_tile_graphics         <= '0;
      addr_sprite_graphics       <= '0;
      addr_color_palettes        <= '0;
      addr_OAM                   <= '0;
      write_data_tile_buffer     <= '0;
      write_data_tile_graphics   <= '0;
      write_data_sprite_graphics <= '0;
      write_data_color_palettes  <= '0;
      write_data_OAM             <= '0;
    end else begin
      rw_tile_buffer     <= 1'b0;
      rw_tile_graphics   <= 1'b0;
      rw_sprite_graphics <= 1'b0;
      rw_color_palettes  <= 1'b0;
      rw_OAM             <= 1'b0;
      if (acc_valid) begin
        case (acc_region)
          3'd0: begin
            addr_tile_buffer <= acc_addr[8:0];
            if (acc_wr) begin
              write_data_tile_buffer <= acc_data;
              rw_tile_buffer         <= 1'b1;
            end
          end
          3'd1: begin
            addr_tile_graphics <= acc_addr;
            if (acc_wr) begin
              write_data_tile_graphics <= acc_data;
              rw_tile_graphics         <= 1'b1;
            end
          end
          3'd2: begin
            addr_sprite_graphics <= acc_addr;
            if (acc_wr) begin
              write_data_sprite_graphics <= acc_data;
              rw_sprite_graphics         <= 1'b1;
            end
          end
          3'd3: begin
            addr_color_palettes <= acc_addr[2:0];
            if (acc_wr) begin
              write_data_color_palettes <= acc_data[23:0];
              rw_color_palettes         <= 1'b1;
            end
          end
          3'd4: begin
            addr_OAM <= acc_addr[7:0];
            if (acc_wr) begin
              write_data_OAM <= acc_data;
              rw_OAM         <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Self-checking bench for ppu_mem_arbiter (default build, strict PPU priority).
// A queue-based reference model predicts every memory port each cycle.
module tb_ppu_mem_arbiter;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_chipselect = 1'b0, host_write = 1'b0;
  logic [13:0] host_address = '0;
  logic [31:0] host_writedata = '0;
  logic        host_waitrequest;
  logic        ppu_req = 1'b0;
  logic [2:0]  ppu_sel = '0;
  logic [10:0] ppu_addr = '0;
  logic        ppu_gnt, ppu_rvalid;
  logic        rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM;
  logic [8:0]  addr_tile_buffer;
  logic [10:0] addr_tile_graphics, addr_sprite_graphics;
  logic [2:0]  addr_color_palettes;
  logic [7:0]  addr_OAM;
  logic [31:0] write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM;
  logic [23:0] write_data_color_palettes;
  logic [7:0]  dropped_count;

  always #5 clk = ~clk;

  ppu_mem_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .host_chipselect(host_chipselect), .host_write(host_write),
    .host_address(host_address), .host_writedata(host_writedata),
    .host_waitrequest(host_waitrequest),
    .ppu_req(ppu_req), .ppu_sel(ppu_sel), .ppu_addr(ppu_addr),
    .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid),
    .rw_tile_buffer(rw_tile_buffer), .rw_tile_graphics(rw_tile_graphics),
    .rw_sprite_graphics(rw_sprite_graphics), .rw_color_palettes(rw_color_palettes),
    .rw_OAM(rw_OAM),
    .addr_tile_buffer(addr_tile_buffer), .addr_tile_graphics(addr_tile_graphics),
    .addr_sprite_graphics(addr_sprite_graphics), .addr_color_palettes(addr_color_palettes),
    .addr_OAM(addr_OAM),
    .write_data_tile_buffer(write_data_tile_buffer),
    .write_data_tile_graphics(write_data_tile_graphics),
    .write_data_sprite_graphics(write_data_sprite_graphics),
    .write_data_color_palettes(write_data_color_palettes),
    .write_data_OAM(write_data_OAM),
    .dropped_count(dropped_count)
  );

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } hw_t;

  hw_t hq[$];   // writes the host still has to present
  hw_t mq[$];   // model of the DUT write FIFO

  int          n_chk = 0, n_fail = 0;
  logic [4:0]  e_rw;
  logic [31:0] e_addr [5];
  logic [31:0] e_data [5];
  logic        e_gnt, e_rv;
  int          e_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] amask(input int r);
    case (r)
      0:       return 32'h1FF;
      1, 2:    return 32'h7FF;
      3:       return 32'h7;
      default: return 32'hFF;
    endcase
  endfunction

  // Predict the outcome of the coming clock edge from current inputs.
  task automatic model(output bit acc);
    int r;
    hw_t e;
    acc = 0;
    if (reset) begin
      mq.delete();
      e_rw = '0; e_gnt = 0; e_rv = 0; e_drop = 0;
      for (int i = 0; i < 5; i++) begin e_addr[i] = '0; e_data[i] = '0; end
      return;
    end
    acc   = host_chipselect && host_write && (mq.size() < DEPTH);
    e_rv  = e_gnt;
    e_gnt = ppu_req;
    e_rw  = '0;
    if (ppu_req && ppu_sel < 3'd5) begin
      r = int'(ppu_sel);
      e_addr[r] = 32'(ppu_addr) & amask(r);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      r = int'(e.a[13:11]);
      if (r < 5) begin
        e_rw[r]   = 1'b1;
        e_addr[r] = 32'(e.a[10:0]) & amask(r);
        e_data[r] = (r == 3) ? (e.d & 32'hFFFFFF) : e.d;
      end else if (e_drop < 255) begin
        e_drop++;
      end
    end
    if (acc) mq.push_back('{a: host_address, d: host_writedata});
  endtask

  // One clock: present the next host write, advance model, compare everything.
  task automatic step();
    bit acc;
    if (hq.size() > 0) begin
      host_chipselect = 1'b1;
      host_write      = 1'b1;
      host_address    = hq[0].a;
      host_writedata  = hq[0].d;
    end else begin
      host_chipselect = ($urandom_range(0, 3) == 0);
      host_write      = 1'b0;
      host_address    = 14'($urandom);
      host_writedata  = $urandom;
    end
    model(acc);
    @(posedge clk); #1;
    if (acc) void'(hq.pop_front());
    chk("gnt",     32'(ppu_gnt), 32'(e_gnt));
    chk("rvalid",  32'(ppu_rvalid), 32'(e_rv));
    chk("waitreq", 32'(host_waitrequest), 32'(mq.size() == DEPTH));
    chk("dropped", 32'(dropped_count), 32'(e_drop));
    chk("rw", 32'({rw_OAM, rw_color_palettes, rw_sprite_graphics, rw_tile_graphics, rw_tile_buffer}), 32'(e_rw));
    chk("addr_tb",  32'(addr_tile_buffer),     e_addr[0]);
    chk("addr_tg",  32'(addr_tile_graphics),   e_addr[1]);
    chk("addr_sg",  32'(addr_sprite_graphics), e_addr[2]);
    chk("addr_pal", 32'(addr_color_palettes),  e_addr[3]);
    chk("addr_oam", 32'(addr_OAM),             e_addr[4]);
    chk("data_tb",  write_data_tile_buffer,     e_data[0]);
    chk("data_tg",  write_data_tile_graphics,   e_data[1]);
    chk("data_sg",  write_data_sprite_graphics, e_data[2]);
    chk("data_pal", 32'(write_data_color_palettes), e_data[3]);
    chk("data_oam", write_data_OAM,             e_data[4]);
  endtask

  // Release the PPU and run until every host write is drained (bounded).
  task automatic drain();
    int n = 0;
    ppu_req = 1'b0;
    while ((hq.size() > 0 || mq.size() > 0) && n < 400) begin
      step();
      n++;
    end
    step();
    chk("drain_done", 32'(hq.size() + mq.size()), 32'd0);
  endtask

  initial begin
    int density;
    // Reset
    repeat (2) step();
    reset = 1'b0;
    step();

    // Palette write lands one cycle after acceptance
    hq.push_back('{a: 14'h1805, d: 32'h00ABCDEF});
    step();
    step();
    chk("pal_rw",   32'(rw_color_palettes), 32'd1);
    chk("pal_addr", 32'(addr_color_palettes), 32'd5);
    chk("pal_data", 32'(write_data_color_palettes), 32'h00ABCDEF);

    // PPU OAM read holds off three pending host writes
    ppu_req = 1'b1; ppu_sel = 3'd4; ppu_addr = 11'h0FF;
    for (int i = 0; i < 3; i++) hq.push_back('{a: {3'd1, 11'(i + 40)}, d: 32'hA000_0000 + i});
    step();
    chk("oam_gnt",  32'(ppu_gnt), 32'd1);
    chk("oam_addr", 32'(addr_OAM), 32'hFF);
    chk("oam_rw",   32'(rw_OAM), 32'd0);
    repeat (4) step();
    chk("oam_rv",   32'(ppu_rvalid), 32'd1);
    chk("oam_hold", 32'(rw_tile_graphics), 32'd0);
    drain();

    // Nine writes behind a continuous PPU read: FIFO fills, 9th is held
    ppu_req = 1'b1; ppu_sel = 3'd0; ppu_addr = 11'h123;
    for (int i = 0; i < 9; i++) hq.push_back('{a: {3'd2, 11'(i)}, d: 32'h5000_0000 + i});
    repeat (11) step();
    chk("full_wait", 32'(host_waitrequest), 32'd1);
    drain();

    // Write to an unmapped region is dropped and counted
    hq.push_back('{a: {3'd6, 11'h012}, d: 32'hDEAD_BEEF});
    drain();
    chk("drop1", 32'(dropped_count), 32'd1);

    // Unmapped PPU request is still granted and gets rvalid
    ppu_req = 1'b1; ppu_sel = 3'd5;
    step();
    chk("unm_gnt", 32'(ppu_gnt), 32'd1);
    ppu_req = 1'b0;
    step();
    chk("unm_rv", 32'(ppu_rvalid), 32'd1);

    // Dropped counter saturates
    for (int i = 0; i < 260; i++) hq.push_back('{a: {3'd7, 11'(i)}, d: $urandom});
    drain();
    chk("drop_sat", 32'(dropped_count), 32'd255);

    // Reset with five entries buffered discards them
    ppu_req = 1'b1; ppu_sel = 3'd1; ppu_addr = 11'h7AB;
    for (int i = 0; i < 5; i++) hq.push_back('{a: {3'd0, 11'(i)}, d: $urandom});
    repeat (7) step();
    reset = 1'b1;
    hq.delete();
    repeat (2) step();
    reset = 1'b0; ppu_req = 1'b0;
    repeat (4) step();
    chk("rst_rw", 32'({rw_OAM, rw_color_palettes, rw_sprite_graphics, rw_tile_graphics, rw_tile_buffer}), 32'd0);
    chk("rst_wait", 32'(host_waitrequest), 32'd0);

    // Randomized traffic with varying PPU load and occasional resets
    density = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) density = $urandom_range(20, 95);
      ppu_req  = ($urandom_range(0, 99) < density);
      ppu_sel  = ($urandom_range(0, 5) == 5) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      ppu_addr = 11'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      if (hq.size() < 2 && $urandom_range(0, 99) < 60) begin
        logic [2:0] rg;
        rg = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        hq.push_back('{a: {rg, 11'($urandom)}, d: $urandom});
      end
      step();
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_mem_arbiter.md
# ppu_mem_arbiter

Shares the five PPU memories (tile buffer, tile graphics, sprite graphics, color palettes, OAM) between host writes arriving over the Avalon slave and read fetches issued by the PPU line/frame loaders. Host writes are buffered in a small FIFO and drained into whichever memory is idle. PPU reads have priority, so display fetches are never delayed by software traffic. Sits between the Avalon slave decode and the memory instances; the PPU loaders talk to memories only through this block.

## Interface
- FIFO_DEPTH, 8: host write FIFO entries (power of two, 2..32)
- STARVE_LIMIT, 64: cycles a FIFO head may wait before forced drain (used only with the configuration macro)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- host_chipselect  in  1  Avalon select
- host_write  in  1  Avalon write strobe
- host_address  in  14  [13:11] region (0 tile buffer, 1 tile graphics, 2 sprite graphics, 3 palettes, 4 OAM, 5-7 unmapped), [10:0] word offset
- host_writedata  in  32  write data
- host_waitrequest  out  1  FIFO full; host must hold the write
- ppu_req  in  1  PPU read request; held until granted
- ppu_sel  in  3  region code, same encoding as host_address[13:11]
- ppu_addr  in  11  word offset
- ppu_gnt  out  1  registered; request presented to memory this cycle
- ppu_rvalid  out  1  read data on the selected memory's read port this cycle
- rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM  out  1 each  1 = write, 0 = read
- addr_tile_buffer  out  9; addr_tile_graphics, addr_sprite_graphics  out  11; addr_color_palettes  out  3; addr_OAM  out  8
- write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM  out  32; write_data_color_palettes  out  24
- dropped_count  out  8  saturating count of writes drained to unmapped regions

## Operation
- Push: host_chipselect & host_write & !host_waitrequest stores {address, writedata}. host_waitrequest = FIFO full (registered count). No push when full, even if a pop occurs that cycle.
- Each cycle the arbiter picks one action: PPU grant if ppu_req and ppu_sel mapped (0-4); else FIFO pop if not empty; else idle.
- PPU grant: next edge drives the selected memory's addr from ppu_addr (truncated to its width), rw = 0; ppu_gnt = 1.
- FIFO pop: next edge drives the head entry's memory with addr (truncated), data (palette takes [23:0]), rw = 1. Unmapped region: nothing driven, dropped_count increments (saturates at 255).
- Non-selected memories: rw = 0, addr and data hold their previous value.
- ppu_req with unmapped ppu_sel: granted with no memory access; ppu_rvalid still asserted (data undefined).
- Different regions are not parallelised: at most one memory access per cycle.

## Timing
- Reset: all rw_* = 0, all addr_* and write_data_* = 0, ppu_gnt = 0, ppu_rvalid = 0, dropped_count = 0, FIFO empty, host_waitrequest = 0. Reset mid-operation discards FIFO contents.
- ppu_req sampled at edge t -> ppu_gnt and memory address at t+1 -> ppu_rvalid at t+2 (1-cycle RAM). Back-to-back requests sustain one read per cycle.
- Host write accepted at t -> earliest memory write at t+1 when PPU idle.
- host_waitrequest updates one cycle after the push that fills the FIFO; a pop deasserts it the following cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged, ordering preserved.

## Configuration
- PPU_ARB_STARVE_GUARD_EN defined: a wait counter runs while the FIFO is non-empty and the head is not popped; at STARVE_LIMIT the next cycle pops the head even if ppu_req is high (ppu_gnt = 0 that cycle, PPU holds its request); counter clears on every pop.
- Undefined: strict PPU priority; host writes may wait indefinitely under continuous ppu_req.

## Test plan
- Reset, then host writes 0x00ABCDEF to address 0x1805 (palette 5), ppu_req low -> rw_color_palettes = 1, addr_color_palettes = 5, write_data_color_palettes = 0xABCDEF one cycle after acceptance.
- ppu_req with ppu_sel = 4, ppu_addr = 0x0FF held with 3 pending host writes -> ppu_gnt next cycle, addr_OAM = 0xFF, rw_OAM = 0, ppu_rvalid one cycle later; host writes drain only after ppu_req drops.
- 9 consecutive host writes with ppu_req held high, FIFO_DEPTH = 8 -> host_waitrequest high after 8th, 9th held; completes after release, all 9 written in order.
- Host write to region 6 -> no rw_* asserted, dropped_count = 1.
- Starve guard enabled, STARVE_LIMIT = 4, ppu_req continuous, one pending write -> ppu_gnt low exactly one cycle, write issued, then grants resume.
- Reset asserted with 5 FIFO entries -> no memory writes after reset, host_waitrequest = 0.
